// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: imem req/gnt/rvalid master, prefetch FIFO and registered IF/ID buffer.
// Optional build macro IF_MISALIGN_CHECK_EN enables sticky misaligned-redirect detection.
module instr_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  input  logic        stall_ip,
  input  logic        redirect_ip,
  input  logic [31:0] redirect_target_ip,
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op,
  output logic        misalign_op
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] in_flight;
  logic [PW-1:0] fifo_wr;
  logic [PW-1:0] fifo_rd;
  logic [PW-1:0] pcq_wr;
  logic [PW-1:0] pcq_rd;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   pcq        [FIFO_DEPTH];
  logic          grant;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fetch_block;
  logic [31:0]   target_pc;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_ip && (redirect_target_ip[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_op = misalign_q;
  assign fetch_block = misalign_q;
  assign target_pc   = redirect_target_ip;
`else
  assign misalign_op = 1'b0;
  assign fetch_block = 1'b0;
  assign target_pc   = redirect_target_ip & 32'hFFFF_FFFC;
`endif

  // Words in flight plus words buffered must never exceed FIFO space, so a push always fits.
  assign in_flight    = outstanding + fifo_count;
  assign imem_req_op  = reset && !redirect_ip && !fetch_block &&
                        (in_flight < CW'(FIFO_DEPTH)) &&
                        (outstanding < CW'(MAX_OUTSTANDING));
  assign imem_addr_op = fetch_pc;
  assign grant        = imem_req_op && imem_gnt_ip;
  assign fifo_empty   = (fifo_count == '0);
  assign push         = imem_rvalid_ip && (kill_cnt == '0) && !redirect_ip;
  assign pop          = !redirect_ip && !stall_ip && !fifo_empty && !fetch_block;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= BOOT_ADDR;
      outstanding <= '0;
      kill_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (redirect_ip) begin
        fetch_pc <= target_pc;
      end else if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_ip);
      // Everything still in flight at a redirect belongs to the old path.
      if (redirect_ip) begin
        kill_cnt <= outstanding - CW'(imem_rvalid_ip);
      end else if (imem_rvalid_ip && (kill_cnt != '0)) begin
        kill_cnt <= kill_cnt - CW'(1);
      end
      if (grant) begin
        pcq_wr <= pcq_wr + PW'(1);
      end
      if (imem_rvalid_ip) begin
        pcq_rd <= pcq_rd + PW'(1);
      end
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts alone define validity.
  always_ff @(posedge clock) begin
    if (grant) begin
      pcq[pcq_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_instr[fifo_wr] <= imem_rdata_ip;
      fifo_pc[fifo_wr]    <= pcq[pcq_rd];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else if (redirect_ip) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_wr <= fifo_wr + PW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // IF/ID buffer: no bypass from the response port, data and pc hold when empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_data_valid_op <= 1'b0;
      instr_data_op       <= NOP;
      pc_op               <= 32'h0;
      pc4_op              <= 32'h0;
    end else if (redirect_ip) begin
      instr_data_valid_op <= 1'b0;
    end else if (!stall_ip) begin
      if (pop) begin
        instr_data_valid_op <= 1'b1;
        instr_data_op       <= fifo_instr[fifo_rd];
        pc_op               <= fifo_pc[fifo_rd];
        pc4_op              <= fifo_pc[fifo_rd] + 32'd4;
      end else begin
        instr_data_valid_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 1-cycle-latency memory responder plus
// hand-timed cycle checks of the request port and the IF/ID buffer.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_op;
  logic [31:0] imem_addr_op;
  logic        imem_gnt_ip = 1'b0;
  logic        imem_rvalid_ip = 1'b0;
  logic [31:0] imem_rdata_ip = 32'h0;
  logic        stall_ip = 1'b0;
  logic        redirect_ip = 1'b0;
  logic [31:0] redirect_target_ip = 32'h0;
  logic        instr_data_valid_op;
  logic [31:0] instr_data_op;
  logic [31:0] pc_op;
  logic [31:0] pc4_op;
  logic        misalign_op;

  logic        gnt_en = 1'b1;
  logic        rv_en  = 1'b1;
  logic [31:0] resp_q [$];
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .imem_req_op        (imem_req_op),
    .imem_addr_op       (imem_addr_op),
    .imem_gnt_ip        (imem_gnt_ip),
    .imem_rvalid_ip     (imem_rvalid_ip),
    .imem_rdata_ip      (imem_rdata_ip),
    .stall_ip           (stall_ip),
    .redirect_ip        (redirect_ip),
    .redirect_target_ip (redirect_target_ip),
    .instr_data_valid_op(instr_data_valid_op),
    .instr_data_op      (instr_data_op),
    .pc_op              (pc_op),
    .pc4_op             (pc4_op),
    .misalign_op        (misalign_op)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0050_0093 ^ (addr << 12);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: grant decided mid-cycle, response one cycle after the grant edge.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      imem_gnt_ip    = gnt_en;
      imem_rvalid_ip = 1'b0;
      if (rv_en && resp_q.size() > 0) begin
        imem_rvalid_ip = 1'b1;
        imem_rdata_ip  = mem_word(resp_q.pop_front());
      end
      if (imem_gnt_ip && imem_req_op) resp_q.push_back(imem_addr_op);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_v(input string tag, input logic v);
    check({tag, ".valid"}, instr_data_valid_op, v);
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] pc);
    check({tag, ".valid"}, instr_data_valid_op, v);
    check({tag, ".pc"}, pc_op, pc);
    check({tag, ".pc4"}, pc4_op, pc + 32'd4);
    check({tag, ".instr"}, instr_data_op, mem_word(pc));
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] addr);
    check({tag, ".req"}, imem_req_op, r);
    if (r) check({tag, ".addr"}, imem_addr_op, addr);
  endtask

  // Leaves the bench 2 time units after the edge that releases reset (before E1).
  task automatic do_reset(input logic g, input logic r, input logic s);
    reset       = 1'b0;
    stall_ip    = s;
    redirect_ip = 1'b0;
    gnt_en      = g;
    rv_en       = r;
    cyc();
    cyc();
    resp_q.delete();
    cyc();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values
    cyc();
    check("rst.req", imem_req_op, 1'b0);
    check("rst.addr", imem_addr_op, 32'h0);
    check("rst.valid", instr_data_valid_op, 1'b0);
    check("rst.instr", instr_data_op, 32'h0000_0013);
    check("rst.pc", pc_op, 32'h0);
    check("rst.pc4", pc4_op, 32'h0);
    check("rst.misalign", misalign_op, 1'b0);

    // 1: first fetch, streaming with bubbles from the 2-entry throttle
    do_reset(1'b1, 1'b1, 1'b0);
    check_req("t1.c0", 1'b1, 32'h0);
    cyc();
    cyc();
    check_v("t1.e2", 1'b0);
    cyc();
    check_if("t1.e3", 1'b1, 32'h0);
    check("t1.first_instr", instr_data_op, 32'h0050_0093);
    cyc(); check_if("t1.e4", 1'b1, 32'h4);
    cyc(); check_if("t1.e5", 1'b0, 32'h4);
    cyc(); check_if("t1.e6", 1'b1, 32'h8);
    cyc(); check_if("t1.e7", 1'b1, 32'hC);

    // 2: stall for 4 edges; FIFO fills, req drops, nothing lost on release
    stall_ip = 1'b1;
    #1;
    check_req("t2.c7", 1'b1, 32'h14);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_if("t2.hold", 1'b1, 32'hC);
      if (i == 3) stall_ip = 1'b0;
      #1;
      check_req("t2.full", 1'b0, 32'h0);
    end
    cyc(); check_if("t2.e12", 1'b1, 32'h10);
    cyc(); check_if("t2.e13", 1'b1, 32'h14);
    cyc(); check_if("t2.e14", 1'b0, 32'h14);
    cyc(); check_if("t2.e15", 1'b1, 32'h18);

    // 3: redirect with 2 requests outstanding; both old words discarded
    do_reset(1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    redirect_ip        = 1'b1;
    redirect_target_ip = 32'h100;
    #1;
    check_req("t3.c2", 1'b0, 32'h0);
    cyc();
    redirect_ip = 1'b0;
    rv_en       = 1'b1;
    check_v("t3.e3", 1'b0);
    #1;
    check_req("t3.c3", 1'b0, 32'h0);
    cyc();
    check_v("t3.e4", 1'b0);
    #1;
    check_req("t3.c4", 1'b1, 32'h100);
    cyc(); check_v("t3.e5", 1'b0);
    cyc(); check_v("t3.e6", 1'b0);
    cyc(); check_if("t3.e7", 1'b1, 32'h100);
    cyc(); check_if("t3.e8", 1'b1, 32'h104);

    // 4: grant withheld; request and address stay put until granted
    do_reset(1'b0, 1'b1, 1'b0);
    check_req("t4.c0", 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_req("t4.wait", 1'b1, 32'h0);
    end
    cyc();
    gnt_en = 1'b1;
    check_req("t4.c5", 1'b1, 32'h0);
    cyc();
    #1;
    check_req("t4.c6", 1'b1, 32'h4);

    // Stall released with FIFO empty while the first word returns
    do_reset(1'b1, 1'b1, 1'b1);
    cyc();
    stall_ip = 1'b0;
    cyc(); check_v("b.e2", 1'b0);
    cyc(); check_if("b.e3", 1'b1, 32'h0);

    // 5: redirect and stall together; redirect wins
    stall_ip           = 1'b1;
    redirect_ip        = 1'b1;
    redirect_target_ip = 32'h200;
    #1;
    check_req("t5.c3", 1'b0, 32'h0);
    cyc();
    check_v("t5.e4", 1'b0);
    stall_ip    = 1'b0;
    redirect_ip = 1'b0;
    #1;
    check_req("t5.c4", 1'b1, 32'h200);
    cyc(); check_v("t5.e5", 1'b0);
    cyc(); check_v("t5.e6", 1'b0);
    cyc(); check_if("t5.e7", 1'b1, 32'h200);

    // 6: misaligned redirect target
    do_reset(1'b1, 1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    redirect_ip        = 1'b1;
    redirect_target_ip = 32'h102;
    #1;
    cyc();
    redirect_ip = 1'b0;
    #1;
`ifdef IF_MISALIGN_CHECK_EN
    check("t6.misalign", misalign_op, 1'b1);
    check_req("t6.c4", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_v("t6.blocked", 1'b0);
      check("t6.sticky", misalign_op, 1'b1);
      check_req("t6.noreq", 1'b0, 32'h0);
    end
`else
    check("t6.misalign", misalign_op, 1'b0);
    check_req("t6.c4", 1'b1, 32'h100);
    cyc();
    cyc();
    cyc();
    check_if("t6.e7", 1'b1, 32'h100);
`endif

    // Asynchronous reset takes effect between edges
    #2;
    reset = 1'b0;
    #1;
    check("arst.valid", instr_data_valid_op, 1'b0);
    check("arst.req", imem_req_op, 1'b0);
    check("arst.pc", pc_op, 32'h0);
    check("arst.misalign", misalign_op, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
